// File: rtl/oh_rseq_pkg.sv
// Shared types and sizing helpers for the oh_rseq reset sequencer.
//   state_t    : sequencer state encoding (ASSERT, GAP, RUN)
//   cnt_width  : width of the min-width / gap counter
//   idx_width  : width of a channel index
package oh_rseq_pkg;

    typedef enum logic [1:0] {
        ASSERT = 2'd0,
        GAP    = 2'd1,
        RUN    = 2'd2
    } state_t;

    // Counter must hold values up to max(minw, hold).
    function automatic int unsigned cnt_width(input int unsigned minw,
                                              input int unsigned hold);
        int unsigned m;
        m = (minw > hold) ? minw : hold;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/oh_dsync.sv
// Multi-stage single-bit synchroniser with synchronous reset to RV.
//   clk : clock
//   rst : synchronous active-high reset, loads RV into every stage
//   d   : asynchronous input
//   q   : synchronised output, PS cycles after d
module oh_dsync #(
    parameter int unsigned PS = 2,
    parameter bit          RV = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [PS-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= {PS{RV}};
        end else begin
            sr <= {sr[PS-2:0], d};
        end
    end

    assign q = sr[PS-1];

endmodule

// File: rtl/oh_rseq.sv
// Multi-domain reset sequencer. Synchronises N active-low reset requests and
// releases N active-low domain resets one at a time in index order, with a
// minimum assertion width and an inter-domain gap. A request on channel i
// resets domain i and every domain above it.
//   clk       : clock
//   rst       : synchronous active-high reset
//   nrst_req  : asynchronous active-low reset request per channel
//   sw_rst    : single-cycle software request, acts as a channel 0 request
//   clr_cause : clears the sticky cause register
//   nrst_out  : registered active-low domain resets
//   done      : high once every domain is released
//   cause     : sticky record of which channels requested a reset
module oh_rseq
    import oh_rseq_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned PS   = 2,
    parameter int unsigned MINW = 8,
    parameter int unsigned HOLD = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] nrst_req,
    input  logic         sw_rst,
    input  logic         clr_cause,
    output logic [N-1:0] nrst_out,
    output logic         done,
    output logic [N-1:0] cause
);

    localparam int unsigned CW = cnt_width(MINW, HOLD);
    localparam int unsigned PW = idx_width(N);

    localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);
    localparam logic [CW-1:0] MINW_END = CW'(MINW - 1);
    localparam logic [CW-1:0] HOLD_END = CW'(HOLD - 1);

    logic [N-1:0]  req_s;
    logic          sync_vld;
    state_t        state;
    logic [PW-1:0] ptr;
    logic [CW-1:0] cnt;

    logic          any_act;
    logic [PW-1:0] a_idx;
    logic [PW-1:0] new_ptr;
    logic [N-1:0]  keep;
    logic [N-1:0]  cause_set;
    logic          at_end;

    // Per-channel request synchronisers; reset value 0 reads as "active".
    for (genvar gi = 0; gi < N; gi++) begin : g_sync
        oh_dsync #(
            .PS (PS),
            .RV (1'b0)
        ) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (nrst_req[gi]),
            .q   (req_s[gi])
        );
    end

    // Goes high when the request chains hold real input samples rather than
    // their reset value, so reset itself never shows up in cause.
    oh_dsync #(
        .PS (PS),
        .RV (1'b0)
    ) u_vld (
        .clk (clk),
        .rst (rst),
        .d   (1'b1),
        .q   (sync_vld)
    );

    // Lowest active request index; sw_rst behaves as a channel 0 request.
    always_comb begin
        any_act = sw_rst;
        a_idx   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (!req_s[i]) begin
                any_act = 1'b1;
                a_idx   = PW'(i);
            end
        end
        if (sw_rst) begin
            a_idx = '0;
        end
    end

    // Channels below the requesting index keep their current value.
    always_comb begin
        keep = '0;
        for (int unsigned j = 0; j < N; j++) begin
            keep[j] = (PW'(j) < a_idx);
        end
    end

    assign new_ptr   = (a_idx < ptr) ? a_idx : ptr;
    assign cause_set = (sync_vld ? ~req_s : '0) | N'(sw_rst);
    assign at_end    = ((state == ASSERT) && (cnt == MINW_END)) ||
                       ((state == GAP)    && (cnt == HOLD_END));

    // Sequencer FSM with registered outputs; a request always wins over a
    // release landing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ASSERT;
            ptr      <= '0;
            cnt      <= '0;
            nrst_out <= '0;
            done     <= 1'b0;
            cause    <= '0;
        end else begin
            // Set wins over a simultaneous clear.
            cause <= cause_set | (cause & {N{~clr_cause}});

            if (any_act) begin
                nrst_out <= nrst_out & keep;
                ptr      <= new_ptr;
                cnt      <= '0;
                state    <= ASSERT;
                done     <= 1'b0;
            end else begin
                case (state)
                    ASSERT, GAP: begin
                        if (at_end) begin
                            nrst_out[ptr] <= 1'b1;
                            cnt           <= '0;
                            if (ptr == LAST_IDX) begin
                                state <= RUN;
                                done  <= 1'b1;
                            end else begin
                                ptr   <= ptr + PW'(1);
                                state <= GAP;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    RUN: begin
                        done <= 1'b1;
                    end
                    default: begin
                        state    <= ASSERT;
                        ptr      <= '0;
                        cnt      <= '0;
                        nrst_out <= '0;
                        done     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oh_rseq.sv
// Self-checking bench for oh_rseq: a thermometer-count model of the release
// sequence is compared every cycle, plus literal timing expectations.
module tb_oh_rseq;

    localparam int unsigned N    = 4;
    localparam int unsigned PS   = 2;
    localparam int unsigned MINW = 8;
    localparam int unsigned HOLD = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] nrst_req;
    logic         sw_rst;
    logic         clr_cause;
    logic [N-1:0] nrst_out;
    logic         done;
    logic [N-1:0] cause;

    always #5 clk = ~clk;

    oh_rseq #(
        .N    (N),
        .PS   (PS),
        .MINW (MINW),
        .HOLD (HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .nrst_req  (nrst_req),
        .sw_rst    (sw_rst),
        .clr_cause (clr_cause),
        .nrst_out  (nrst_out),
        .done      (done),
        .cause     (cause)
    );

    int checks = 0;
    int errors = 0;
    int t      = 0;

    task automatic chk(input string name, input logic [N-1:0] got,
                       input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got %b expected %b", name, t, got, exp);
        end
    endtask

    // Model: the outputs are a thermometer of `rel` released domains. Each
    // quiet cycle counts toward the next release; the first release after a
    // request needs MINW quiet cycles, later ones need HOLD.
    logic [N-1:0] m_sq [PS];
    bit           m_sv [PS];
    int           m_rel;
    int           m_quiet;
    int           m_need;
    logic [N-1:0] m_cause;

    function automatic logic [N-1:0] therm(input int r);
        logic [N-1:0] v;
        for (int i = 0; i < int'(N); i++) v[i] = (i < r);
        return v;
    endfunction

    always @(posedge clk) begin
        logic [N-1:0] rs;
        bit           rv;
        int           a;
        logic [N-1:0] setv;
        if (rst) begin
            for (int k = 0; k < int'(PS); k++) begin
                m_sq[k] = '0;
                m_sv[k] = 1'b0;
            end
            m_rel   = 0;
            m_quiet = 0;
            m_need  = MINW;
            m_cause = '0;
        end else begin
            rs = m_sq[PS-1];
            rv = m_sv[PS-1];
            a  = N;
            for (int i = int'(N) - 1; i >= 0; i--) if (!rs[i]) a = i;
            if (sw_rst) a = 0;
            setv    = rv ? ~rs : '0;
            setv[0] = setv[0] | sw_rst;
            m_cause = setv | (clr_cause ? '0 : m_cause);
            if (a < int'(N)) begin
                if (a < m_rel) m_rel = a;
                m_quiet = 0;
                m_need  = MINW;
            end else if (m_rel < int'(N)) begin
                m_quiet++;
                if (m_quiet == m_need) begin
                    m_rel++;
                    m_quiet = 0;
                    m_need  = HOLD;
                end
            end
            for (int k = int'(PS) - 1; k > 0; k--) begin
                m_sq[k] = m_sq[k-1];
                m_sv[k] = m_sv[k-1];
            end
            m_sq[0] = nrst_req;
            m_sv[0] = 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model_nrst_out", nrst_out, therm(m_rel));
        chk("model_done", N'(done), N'(m_rel == int'(N)));
        chk("model_cause", cause, m_cause);
    end

    // t = c means the value observed in cycle c, where cycle 0 is the first
    // edge with rst sampled low.
    task automatic goto(input int c);
        while (t < c) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic powerup_checks(input string tag);
        goto(1);  chk({tag, "_c1"},   nrst_out, 4'b0000);
        goto(9);  chk({tag, "_c9"},   nrst_out, 4'b0000);
        goto(10); chk({tag, "_c10"},  nrst_out, 4'b0001);
        goto(25); chk({tag, "_c25"},  nrst_out, 4'b0001);
        goto(26); chk({tag, "_c26"},  nrst_out, 4'b0011);
        goto(42); chk({tag, "_c42"},  nrst_out, 4'b0111);
        goto(57); chk({tag, "_done57"}, N'(done), 4'b0000);
        goto(58); chk({tag, "_c58"},  nrst_out, 4'b1111);
                  chk({tag, "_done58"}, N'(done), 4'b0001);
                  chk({tag, "_cause"}, cause, 4'b0000);
    endtask

    initial begin
        rst       = 1'b1;
        nrst_req  = '1;
        sw_rst    = 1'b0;
        clr_cause = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        t   = 0;

        powerup_checks("pu");

        // Mid-cascade request on channel 2 for 3 cycles.
        goto(70);  nrst_req[2] = 1'b0;
        goto(72);  chk("mid_c72", nrst_out, 4'b1111);
        goto(73);  chk("mid_c73", nrst_out, 4'b0011);
                   chk("mid_cause", cause, 4'b0100);
                   nrst_req[2] = 1'b1;
        goto(82);  chk("mid_c82", nrst_out, 4'b0011);
        goto(83);  chk("mid_c83", nrst_out, 4'b0111);
        goto(98);  chk("mid_c98", nrst_out, 4'b0111);
        goto(99);  chk("mid_c99", nrst_out, 4'b1111);
        goto(110); clr_cause = 1'b1;
        goto(111); clr_cause = 1'b0;
                   chk("clr1_cause", cause, 4'b0000);

        // Single-cycle request on channel 0: minimum width applies.
        goto(115); nrst_req[0] = 1'b0;
        goto(116); nrst_req[0] = 1'b1;
        goto(117); chk("mw_c117", nrst_out, 4'b1111);
        goto(118); chk("mw_c118", nrst_out, 4'b0000);
        goto(125); chk("mw_c125", nrst_out, 4'b0000);
        goto(126); chk("mw_c126", nrst_out, 4'b0001);
        goto(142); chk("mw_c142", nrst_out, 4'b0011);

        // Channel 1 request during the gap after 0011.
        goto(145); nrst_req[1] = 1'b0;
        goto(147); chk("gap_c147", nrst_out, 4'b0011);
                   nrst_req[1] = 1'b1;
        goto(148); chk("gap_c148", nrst_out, 4'b0001);
        goto(156); chk("gap_c156", nrst_out, 4'b0001);
        goto(157); chk("gap_c157", nrst_out, 4'b0011);
        goto(173); chk("gap_c173", nrst_out, 4'b0111);
        goto(188); chk("gap_c188", nrst_out, 4'b0111);
        goto(189); chk("gap_c189", nrst_out, 4'b1111);
                   chk("gap_cause", cause, 4'b0011);

        // sw_rst with a simultaneous clear: set wins on bit 0.
        goto(195); chk("sw_c195", nrst_out, 4'b1111);
                   sw_rst    = 1'b1;
                   clr_cause = 1'b1;
        goto(196); sw_rst    = 1'b0;
                   clr_cause = 1'b0;
                   chk("sw_c196", nrst_out, 4'b0000);
                   chk("sw_cause", cause, 4'b0001);
                   chk("sw_done", N'(done), 4'b0000);
        goto(203); chk("sw_c203", nrst_out, 4'b0000);
        goto(204); chk("sw_c204", nrst_out, 4'b0001);
        goto(215); clr_cause = 1'b1;
        goto(216); clr_cause = 1'b0;
                   chk("clr2_cause", cause, 4'b0000);

        // Channel 3 request above ptr lands on the release boundary.
        goto(217); nrst_req[3] = 1'b0;
        goto(218); nrst_req[3] = 1'b1;
        goto(220); chk("hi_c220", nrst_out, 4'b0001);
                   chk("hi_cause", cause, 4'b1000);
        goto(227); chk("hi_c227", nrst_out, 4'b0001);
        goto(228); chk("hi_c228", nrst_out, 4'b0011);

        // Reset mid-sequence, then the power-up timing again.
        goto(231); rst = 1'b1;
        goto(232); chk("rst_nrst_out", nrst_out, 4'b0000);
                   chk("rst_done", N'(done), 4'b0000);
                   chk("rst_cause", cause, 4'b0000);
        goto(234); rst = 1'b0;
        t = 0;
        powerup_checks("rr");
        goto(62);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
